// File: rtl/io_dec_pkg.sv
// io_dec_pkg: FSM state encoding and power-on decode table shared by the I/O port decoder.
package io_dec_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACTIVE} state_t;
    localparam int MAX_CH = 16;
    localparam logic [7:0] DEF_BASE [MAX_CH] = '{
        8'h90, 8'h98, 8'hA0, 8'hA8, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic [7:0] DEF_MASK [MAX_CH] = '{
        8'hF8, 8'hF8, 8'hF8, 8'hF8, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam logic DEF_EN [MAX_CH] = '{
        1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
endpackage

// File: rtl/io_prio_match.sv
// io_prio_match: compares the address against every channel window; lowest matching index wins.
module io_prio_match #(
    parameter int NUM_CH = 8,
    parameter int ADDR_W = 8,
    localparam int IDX_W = $clog2(NUM_CH)
) (
    input  logic [ADDR_W-1:0]             addr,
    input  logic [NUM_CH-1:0]             en,
    input  logic [NUM_CH-1:0][ADDR_W-1:0] base,
    input  logic [NUM_CH-1:0][ADDR_W-1:0] mask,
    output logic                          hit,
    output logic [IDX_W-1:0]              idx
);
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (en[i] && ((addr ^ base[i]) & mask[i]) == '0) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/io_port_decoder_ws.sv
// io_port_decoder_ws: registered Z80 I/O decoder with programmable windows and per-channel wait states.
module io_port_decoder_ws
    import io_dec_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int ADDR_W = 8,
    parameter int WS_W   = 3,
    localparam int IDX_W = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              iorq_n,
    input  logic              m1_n,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic              cfg_en,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_mask,
    input  logic [WS_W-1:0]   cfg_ws,
    output logic [NUM_CH-1:0] cs_n,
    output logic              hit,
    output logic              wait_n
);
    logic [NUM_CH-1:0]             en_q;
    logic [NUM_CH-1:0][ADDR_W-1:0] base_q, mask_q;
    logic [NUM_CH-1:0][WS_W-1:0]   ws_q;
    logic                          io_en, io_en_q, start, m_hit, need_ws;
    logic [IDX_W-1:0]              m_idx;
    state_t                        state, state_nx;
    logic [WS_W-1:0]               cnt, cnt_nx;
    logic [NUM_CH-1:0]             cs_nx;
    logic                          hit_nx, wait_nx;

    assign io_en   = ~iorq_n & m1_n;
    assign start   = io_en & ~io_en_q;
    assign need_ws = m_hit && ws_q[m_idx] != '0;

    io_prio_match #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) u_match (
        .addr(addr), .en(en_q), .base(base_q), .mask(mask_q), .hit(m_hit), .idx(m_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                en_q[i]   <= DEF_EN[i];
                base_q[i] <= ADDR_W'(DEF_BASE[i]);
                mask_q[i] <= ADDR_W'(DEF_MASK[i]);
            end
            ws_q <= '0;
        end else if (cfg_we && 32'(cfg_idx) < NUM_CH) begin
            en_q[cfg_idx]   <= cfg_en;
            base_q[cfg_idx] <= cfg_base;
            mask_q[cfg_idx] <= cfg_mask;
            ws_q[cfg_idx]   <= cfg_ws;
        end
    end

    // Channel and wait count are captured into the output/counter registers at start,
    // so later address or table changes cannot disturb the access in flight.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cs_nx    = cs_n;
        hit_nx   = hit;
        wait_nx  = wait_n;
        if (state == IDLE && start) begin
            cs_nx    = m_hit ? ~(NUM_CH'(1) << m_idx) : '1;
            hit_nx   = m_hit;
            cnt_nx   = ws_q[m_idx];
            state_nx = need_ws ? WAIT : ACTIVE;
            wait_nx  = ~need_ws;
        end else if (state != IDLE && !io_en) begin
            state_nx = IDLE;
            cs_nx    = '1;
            hit_nx   = 1'b0;
            wait_nx  = 1'b1;
        end else if (state == WAIT) begin
            cnt_nx   = cnt - 1'b1;
            state_nx = cnt == WS_W'(1) ? ACTIVE : WAIT;
            wait_nx  = cnt == WS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            io_en_q <= 1'b0;
            cnt     <= '0;
            cs_n    <= '1;
            hit     <= 1'b0;
            wait_n  <= 1'b1;
        end else begin
            state   <= state_nx;
            io_en_q <= io_en;
            cnt     <= cnt_nx;
            cs_n    <= cs_nx;
            hit     <= hit_nx;
            wait_n  <= wait_nx;
        end
    end
endmodule

// File: tb/tb_io_port_decoder_ws.sv
// tb_io_port_decoder_ws: directed checks of decode, priority, wait states, aborts and reset.
module tb_io_port_decoder_ws;
    import io_dec_pkg::*;

    logic       clk = 0;
    logic       reset_n = 0;
    logic [7:0] addr = 0;
    logic       iorq_n = 1, m1_n = 1, cfg_we = 0, cfg_en = 0;
    logic [2:0] cfg_idx = 0, cfg_ws = 0;
    logic [7:0] cfg_base = 0, cfg_mask = 0;
    logic [7:0] cs_n;
    logic       hit, wait_n;
    int         n_tests = 0, n_fail = 0, lows;

    io_port_decoder_ws dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .iorq_n(iorq_n), .m1_n(m1_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_base(cfg_base),
        .cfg_mask(cfg_mask), .cfg_ws(cfg_ws), .cs_n(cs_n), .hit(hit), .wait_n(wait_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [2:0] idx, input logic en, input logic [7:0] base,
                       input logic [7:0] mask, input logic [2:0] ws);
        cfg_idx = idx; cfg_en = en; cfg_base = base; cfg_mask = mask; cfg_ws = ws;
        cfg_we = 1;
        tick();
        cfg_we = 0;
    endtask

    task automatic outs(input string tag, input logic [7:0] e_cs, input logic e_hit, input logic e_wait);
        check({tag, ".cs_n"}, 32'(cs_n), 32'(e_cs));
        check({tag, ".hit"}, 32'(hit), 32'(e_hit));
        check({tag, ".wait_n"}, 32'(wait_n), 32'(e_wait));
    endtask

    task automatic release_io(input string tag);
        iorq_n = 1; m1_n = 1;
        tick();
        outs(tag, 8'hFF, 0, 1);
        check({tag, ".idle"}, 32'(dut.state), 32'(IDLE));
    endtask

    initial begin
        tick(); tick();
        outs("rst", 8'hFF, 0, 1);
        check("rst.state", 32'(dut.state), 32'(IDLE));
        reset_n = 1;
        tick();

        // 1: default ch1, no wait states, one clock latency
        addr = 8'h99; iorq_n = 0;
        #1 check("t1.pre", 32'(cs_n), 32'hFF);
        for (int i = 0; i < 4; i++) begin
            tick();
            outs("t1", 8'hFD, 1, 1);
        end
        release_io("t1.rel");

        // 2: ch2 with 3 wait states
        cfg(3'd2, 1, 8'hA0, 8'hF8, 3'd3);
        addr = 8'hA1; iorq_n = 0;
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!wait_n) lows++;
            check("t2.cs", 32'(cs_n), 32'hFB);
        end
        check("t2.lows", 32'(lows), 32'd3);
        check("t2.active", 32'(dut.state), 32'(ACTIVE));
        release_io("t2.rel");

        // 3: overlapping windows, lower index wins; mid-access table write ignored
        cfg(3'd4, 1, 8'h98, 8'hFF, 3'd0);
        addr = 8'h98; iorq_n = 0;
        tick();
        outs("t3.prio", 8'hFD, 1, 1);
        release_io("t3.rel1");
        cfg(3'd1, 0, 8'h98, 8'hF8, 3'd0);
        addr = 8'h98; iorq_n = 0;
        tick();
        outs("t3.ch4", 8'hEF, 1, 1);
        addr = 8'h00;
        cfg(3'd4, 0, 8'h98, 8'hFF, 3'd0);
        outs("t3.hold", 8'hEF, 1, 1);
        release_io("t3.rel2");

        // 4: unmapped port and interrupt acknowledge
        addr = 8'h10; iorq_n = 0;
        tick(); tick();
        outs("t4.miss", 8'hFF, 0, 1);
        check("t4.track", 32'(dut.state), 32'(ACTIVE));
        release_io("t4.rel");
        addr = 8'h90; iorq_n = 0; m1_n = 0;
        tick(); tick();
        outs("t4.inta", 8'hFF, 0, 1);
        check("t4.inta.st", 32'(dut.state), 32'(IDLE));
        release_io("t4.rel2");

        // 5: abort in the middle of a 7-clock wait
        cfg(3'd0, 1, 8'h90, 8'hF8, 3'd7);
        addr = 8'h91; iorq_n = 0;
        tick();
        outs("t5.w1", 8'hFE, 1, 0);
        tick();
        outs("t5.w2", 8'hFE, 1, 0);
        release_io("t5.abort");

        // 6: asynchronous reset mid-wait restores outputs and table
        addr = 8'h91; iorq_n = 0;
        tick(); tick();
        check("t6.pre", 32'(wait_n), 32'd0);
        reset_n = 0;
        #2;
        outs("t6.async", 8'hFF, 0, 1);
        iorq_n = 1;
        tick();
        reset_n = 1;
        tick();
        addr = 8'h98; iorq_n = 0;
        tick();
        outs("t6.def1", 8'hFD, 1, 1);
        release_io("t6.rel1");
        addr = 8'h91; iorq_n = 0;
        tick();
        outs("t6.def0", 8'hFE, 1, 1);
        release_io("t6.rel2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
